// File: rtl/uart_rx_os16.sv
// 16x-oversampled UART receiver: start-bit validation at mid-bit, LSB-first data, sticky rdy/overrun.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check (default build is 8N1).
module uart_rx_os16 #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 rxclk_en,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] SMP_HALF = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SW-1:0]          sample_q, sample_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   rdy_q, rdy_d;
    logic                   busy_q, busy_d;
    logic                   fe_q, fe_d;
    logic                   ovr_q, ovr_d;
    logic                   rx_s;
    logic                   commit;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   perr_q, perr_d;
`endif

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], rx};
        state_d  = state_q;
        sample_d = sample_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        rdy_d    = rdy_q;
        fe_d     = fe_q;
        ovr_d    = ovr_q;
        commit   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
        perr_d   = perr_q;
`endif
        if (rxclk_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d  = S_START;
                        sample_d = SW'(1);
                    end
                end
                S_START: begin
                    // Line must still be low at mid start bit, otherwise it was noise.
                    if (sample_q == SMP_HALF) begin
                        sample_d = '0;
                        bit_d    = '0;
                        state_d  = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        sample_d = sample_q + SW'(1);
                    end
                end
                S_DATA: begin
                    if (sample_q == SMP_LAST) begin
                        shift_d  = {rx_s, shift_q[DATA_BITS-1:1]};
                        sample_d = '0;
                        bit_d    = bit_q + BW'(1);
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        sample_d = sample_q + SW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (sample_q == SMP_LAST) begin
                        par_d    = rx_s;
                        sample_d = '0;
                        state_d  = S_STOP;
                    end else begin
                        sample_d = sample_q + SW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (sample_q == SMP_LAST) begin
                        commit   = 1'b1;
                        sample_d = '0;
                        bit_d    = '0;
                        state_d  = S_IDLE;
                    end else begin
                        sample_d = sample_q + SW'(1);
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    sample_d = '0;
                    bit_d    = '0;
                end
            endcase
        end
        if (rdy_clr) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end
        // A commit overrides a simultaneous clear; overrun reflects rdy before the clear.
        if (commit) begin
            data_d = shift_q;
            rdy_d  = 1'b1;
            fe_d   = ~rx_s;
            ovr_d  = rdy_q;
`ifdef UART_RX_PARITY_EN
            perr_d = ^{shift_q, par_q};
`endif
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            sync_q   <= '1;
            sample_q <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            fe_q     <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            sample_q <= sample_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
            fe_q     <= fe_d;
            ovr_q    <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q    <= par_d;
            perr_q   <= perr_d;
`endif
        end
    end

    assign data      = data_q;
    assign rdy       = rdy_q;
    assign busy      = busy_q;
    assign frame_err = fe_q;
    assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scoreboard bench for uart_rx_os16: a serial driver pushes expected outcomes per frame,
// a monitor pops one entry each time busy falls and compares the host-visible outputs.
module tb_uart_rx_os16;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       rxclk_en = 1'b0;
    logic       rx = 1'b1;
    logic       rdy_clr = 1'b0;
    logic [7:0] data;
    logic       rdy, busy, frame_err, overrun, parity_err;

    uart_rx_os16 dut (
        .CLK(CLK), .RST_N(RST_N), .rxclk_en(rxclk_en), .rx(rx), .rdy_clr(rdy_clr),
        .data(data), .rdy(rdy), .busy(busy), .frame_err(frame_err),
        .overrun(overrun), .parity_err(parity_err)
    );

    always #5 CLK = ~CLK;

    // One oversample tick every 4th clock.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge CLK);
            cnt = cnt + 1;
            rxclk_en = (cnt % 4 == 0);
        end
    end

    typedef struct {
        logic       is_byte;
        logic [7:0] d;
        logic       rdy, fe, ovr, pe;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference state of the host-visible registers.
    logic       m_rdy = 1'b0, m_fe = 1'b0, m_ovr = 1'b0, m_pe = 1'b0;
    logic [7:0] m_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rdy = 0; m_fe = 0; m_ovr = 0; m_pe = 0; m_data = 0;
    endtask

    task automatic push_glitch();
        exp_t e;
        e.is_byte = 1'b0; e.d = m_data; e.rdy = m_rdy; e.fe = m_fe; e.ovr = m_ovr; e.pe = m_pe;
        sb.push_back(e);
    endtask

    task automatic push_byte(input logic [7:0] d, input logic stop, input logic par);
        exp_t e;
        e.is_byte = 1'b1;
        e.d   = d;
        e.rdy = 1'b1;
        e.fe  = !stop;
        e.ovr = m_rdy;
        e.pe  = PAR_EN ? (^{d, par}) : 1'b0;
        m_rdy = 1'b1; m_data = d; m_fe = e.fe; m_ovr = e.ovr; m_pe = e.pe;
        sb.push_back(e);
        // A low stop bit restarts a start search that then sees the line back high.
        if (!stop) push_glitch();
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge CLK); while (!rxclk_en);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int gap);
        wait_ticks(1);
        push_byte(d, stop, par);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
        if (PAR_EN) begin
            rx = par;
            wait_ticks(16);
        end
        rx = stop;
        wait_ticks(16);
        rx = 1'b1;
        if (gap > 0) wait_ticks(gap);
    endtask

    task automatic send_glitch(input int len);
        wait_ticks(1);
        push_glitch();
        rx = 1'b0;
        wait_ticks(len);
        rx = 1'b1;
        wait_ticks(30);
    endtask

    task automatic do_clear();
        rdy_clr = 1'b1;
        @(posedge CLK);
        #1 rdy_clr = 1'b0;
        m_rdy = 1'b0; m_ovr = 1'b0;
        chk("clr_rdy", rdy, m_rdy);
        chk("clr_overrun", overrun, m_ovr);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data"}, data, 0);
        chk({tag, "_rdy"}, rdy, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_parity_err"}, parity_err, 0);
    endtask

    // Monitor: each fall of busy ends one frame attempt.
    logic busy_prev = 1'b0;
    always @(negedge CLK) begin
        if (!RST_N) begin
            busy_prev = 1'b0;
        end else begin
            if (busy_prev && !busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame_end", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk(e.is_byte ? "byte_data" : "glitch_data", data, e.d);
                    chk(e.is_byte ? "byte_rdy" : "glitch_rdy", rdy, e.rdy);
                    chk(e.is_byte ? "byte_frame_err" : "glitch_frame_err", frame_err, e.fe);
                    chk(e.is_byte ? "byte_overrun" : "glitch_overrun", overrun, e.ovr);
                    chk(e.is_byte ? "byte_parity_err" : "glitch_parity_err", parity_err, e.pe);
                end
            end
            busy_prev = busy;
        end
    end

    initial begin
        int waited;
        #3 RST_N = 1'b0;
        #20;
        check_all_zero("reset");
        @(posedge CLK);
        #1 RST_N = 1'b1;
        wait_ticks(4);

        send_frame(8'h55, 1'b1, 1'b0, 32);       // clean byte
        do_clear();
        send_glitch(4);                          // short low pulse
        send_frame(8'hA3, 1'b0, 1'b1, 32);       // framing error
        do_clear();
        send_frame(8'h12, 1'b1, 1'b0, 0);        // back-to-back, no clear
        send_frame(8'h34, 1'b1, 1'b1, 32);
        do_clear();

        // Reset in the middle of bit 3 of 0xFF.
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(16);
        rx = 1'b1;
        wait_ticks(56);
        RST_N = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        model_reset();
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        wait_ticks(4);
        send_frame(8'h0F, 1'b1, 1'b0, 32);
        do_clear();

        send_frame(8'h07, 1'b1, 1'b0, 32);       // parity bit 0
        do_clear();
        send_frame(8'h07, 1'b1, 1'b1, 32);       // parity bit 1
        do_clear();

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(5) == 0) begin
                send_glitch($urandom_range(6, 1));
            end else begin
                logic       stop;
                int         gap;
                stop = ($urandom_range(4) != 0);
                gap  = (stop && $urandom_range(2) == 0) ? 0 : $urandom_range(40, 20);
                send_frame(8'($urandom), stop, 1'($urandom), gap);
                if (gap > 0 && $urandom_range(2) != 0) do_clear();
            end
        end

        waited = 0;
        while (sb.size() != 0 && waited < 2000) begin
            @(posedge CLK);
            waited = waited + 1;
        end
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
